// File: rtl/l_shl_arbiter_if.sv
// rtl/l_shl_arbiter_if.sv - start/done handshake and operand bus to the shared L_shl unit
interface l_shl_arbiter_if;
  logic [31:0] L_shl_a;
  logic [15:0] L_shl_b;
  logic        L_shl_ready;
  logic [31:0] L_shl_in;
  logic        L_shl_done;

  modport master (
    output L_shl_a,
    output L_shl_b,
    output L_shl_ready,
    input  L_shl_in,
    input  L_shl_done
  );

  modport slave (
    input  L_shl_a,
    input  L_shl_b,
    input  L_shl_ready,
    output L_shl_in,
    output L_shl_done
  );
endinterface

// File: rtl/l_shl_arbiter.sv
// rtl/l_shl_arbiter.sv - round-robin sharing of one multi-cycle L_shl unit among NUM_REQ requesters
// Optional WAIT-state timeout is built when ARB_TIMEOUT_EN is defined.
module l_shl_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*16-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [31:0]             req_result,
  output logic                    req_err,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy,
  l_shl_arbiter_if.master         lshl
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   winner;
  logic               win_valid;
  logic [NUM_REQ-1:0] grant_q;
  logic [31:0]        op_a;
  logic [15:0]        op_b;
  logic [31:0]        res_q;
  logic               timed_out;
  logic               err_flag;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Scan downward so the candidate closest after rr_ptr is the last one kept.
  always_comb begin
    winner    = rr_ptr;
    win_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_ready[ptr_add(rr_ptr, k)]) begin
        winner    = ptr_add(rr_ptr, k);
        win_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    busy             = (state != ST_IDLE);
    grant            = grant_q;
    lshl.L_shl_ready = (state == ST_ISSUE);
    lshl.L_shl_a     = '0;
    lshl.L_shl_b     = '0;
    req_done         = '0;
    req_result       = '0;
    req_err          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_valid) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        lshl.L_shl_a = op_a;
        lshl.L_shl_b = op_b;
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        lshl.L_shl_a = op_a;
        lshl.L_shl_b = op_b;
        if (lshl.L_shl_done || timed_out) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        req_done   = grant_q;
        req_result = res_q;
        req_err    = err_flag;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands are frozen at grant; requester-side changes afterwards do not reach L_shl.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= PTR_W'(NUM_REQ - 1);
      grant_q <= '0;
      op_a    <= '0;
      op_b    <= '0;
      res_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            for (int i = 0; i < NUM_REQ; i++) begin
              grant_q[i] <= (PTR_W'(i) == winner);
            end
            op_a   <= req_a[32*winner +: 32];
            op_b   <= req_b[16*winner +: 16];
            rr_ptr <= winner;
          end
        end
        ST_WAIT: begin
          if (lshl.L_shl_done) begin
            res_q <= lshl.L_shl_in;
          end else if (timed_out) begin
            res_q <= '0;
          end
        end
        ST_RESP: begin
          grant_q <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ST_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      // A done arriving on the timeout cycle still counts as a good completion.
      if (state == ST_WAIT && (lshl.L_shl_done || timed_out)) begin
        err_q <= !lshl.L_shl_done;
      end
    end
  end

  assign timed_out = (state == ST_WAIT) && (wait_cnt == 8'(TIMEOUT));
  assign err_flag  = err_q;
`else
  assign timed_out = 1'b0;
  assign err_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_l_shl_arbiter.sv
// tb/tb_l_shl_arbiter.sv - self-checking bench for l_shl_arbiter with an L_shl responder and timeline model
module tb_l_shl_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*16-1:0] req_b;
  logic [N-1:0]    req_done;
  logic [31:0]     req_result;
  logic            req_err;
  logic [N-1:0]    grant;
  logic            busy;

  l_shl_arbiter_if lif ();

  l_shl_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_done   (req_done),
    .req_result (req_result),
    .req_err    (req_err),
    .grant      (grant),
    .busy       (busy),
    .lshl       (lif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [N-1:0] keep_mask;
  bit           rand_ops;
  bit           mute;
  int           force_lat;
  int           cur_lat;

  bit           m_busy;
  int           m_owner, m_issue, m_done_at, m_last;
  logic [31:0]  m_a, m_res;
  logic [15:0]  m_b;
  bit           m_err;

  int           resp_cnt;
  logic [31:0]  resp_val;
  int           n_issue;
  int           done_log[$];
  logic [31:0]  last_result;
  logic         last_err;
  int           n0, n1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Saturating left shift; non-positive counts shift right arithmetically.
  function automatic logic [31:0] lshl_ref(input logic [31:0] a, input logic [15:0] b);
    longint v;
    int     s;
    v = longint'($signed(a));
    s = int'($signed(b));
    if (s <= 0) begin
      s = -s;
      if (s > 31) s = 31;
      return 32'(v >>> s);
    end
    for (int i = 0; i < s; i++) begin
      v = v * 2;
      if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (v < -64'sd2147483648) return 32'h8000_0000;
    end
    return 32'(v);
  endfunction

  function automatic int scan(input logic [N-1:0] vec, input int last);
    for (int k = 1; k <= N; k++) begin
      if (vec[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    logic [N-1:0]    p_req;
    logic [N*32-1:0] p_a;
    logic [N*16-1:0] p_b;
    bit              p_rst;
    logic [N-1:0]    oh;
    bit              done_now;
    int              w;
    p_req = req_ready;
    p_a   = req_a;
    p_b   = req_b;
    p_rst = !reset;
    @(posedge clk);
    #1;
    cyc++;

    lif.L_shl_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        lif.L_shl_done = 1'b1;
        lif.L_shl_in   = resp_val;
      end
    end

    if (p_rst) begin
      m_busy = 1'b0;
      m_last = N - 1;
    end else if (m_busy && cyc == m_done_at + 1) begin
      m_busy = 1'b0;
    end else if (!m_busy && p_req != '0) begin
      w       = scan(p_req, m_last);
      m_owner = w;
      m_issue = cyc;
      m_a     = p_a[32*w +: 32];
      m_b     = p_b[16*w +: 16];
      cur_lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
      if (mute) begin
`ifdef ARB_TIMEOUT_EN
        m_done_at = cyc + TO + 2;
`else
        m_done_at = cyc + 1000000;
`endif
        m_res = 32'h0;
        m_err = 1'b1;
      end else begin
        m_done_at = cyc + cur_lat + 1;
        m_res     = lshl_ref(m_a, m_b);
        m_err     = 1'b0;
      end
      m_last = w;
      m_busy = 1'b1;
    end

    oh = '0;
    if (m_busy) oh[m_owner] = 1'b1;
    done_now = m_busy && (cyc == m_done_at);
    chk("grant", grant, oh);
    chk("busy", busy, m_busy);
    chk("L_shl_ready", lif.L_shl_ready, m_busy && (cyc == m_issue));
    if (m_busy && cyc < m_done_at) begin
      chk("L_shl_a", lif.L_shl_a, m_a);
      chk("L_shl_b", lif.L_shl_b, m_b);
    end
    chk("req_done", req_done, done_now ? oh : '0);
    if (done_now) begin
      chk("req_result", req_result, m_res);
      chk("req_err", req_err, m_err);
    end else begin
      chk("req_err_idle", req_err, 1'b0);
    end

    if (req_done != '0) begin
      for (int i = 0; i < N; i++) if (req_done[i]) done_log.push_back(i);
      last_result = req_result;
      last_err    = req_err;
      req_ready   = req_ready & ~(req_done & ~keep_mask);
    end

    if (lif.L_shl_ready) begin
      n_issue++;
      if (!mute) begin
        resp_cnt = cur_lat;
        resp_val = lshl_ref(lif.L_shl_a, lif.L_shl_b);
      end
    end

    if (rand_ops) begin
      for (int i = 0; i < N; i++) begin
        req_a[32*i +: 32] = $urandom;
        req_b[16*i +: 16] = 16'($urandom_range(0, 40)) - 16'd8;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, '0);
    chk("rst_done", req_done, '0);
    chk("rst_ready", lif.L_shl_ready, 1'b0);
    resp_cnt       = 0;
    lif.L_shl_done = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    req_ready      = '0;
    req_a          = '0;
    req_b          = '0;
    lif.L_shl_in   = '0;
    lif.L_shl_done = 1'b0;
    keep_mask      = '0;
    rand_ops       = 1'b1;
    mute           = 1'b0;
    force_lat      = 0;
    cur_lat        = 1;
    m_busy         = 1'b0;
    m_owner        = 0;
    m_issue        = 0;
    m_done_at      = 0;
    m_last         = N - 1;
    m_a            = '0;
    m_b            = '0;
    m_res          = '0;
    m_err          = 1'b0;
    resp_cnt       = 0;
    resp_val       = '0;
    n_issue        = 0;
    last_result    = '0;
    last_err       = 1'b0;

    tick();
    tick();
    chk("reset_result", req_result, 32'h0);
    reset = 1'b1;
    tick();

    // Single request, 2-cycle L_shl
    rand_ops          = 1'b0;
    force_lat         = 2;
    req_a             = '0;
    req_b             = '0;
    req_a[31:0]       = 32'h0001_2345;
    req_b[15:0]       = 16'd3;
    n0                = done_log.size();
    n1                = n_issue;
    req_ready         = 4'b0001;
    repeat (8) tick();
    chk("t1_ops", done_log.size() - n0, 1);
    chk("t1_issues", n_issue - n1, 1);
    chk("t1_result", last_result, 32'h0009_1A28);

    // Full contention from reset: strict order 0,1,2,3
    do_reset();
    rand_ops  = 1'b1;
    force_lat = 0;
    n0        = done_log.size();
    req_ready = 4'b1111;
    repeat (40) tick();
    chk("t2_ops", done_log.size() - n0, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", (done_log.size() > n0 + k) ? done_log[n0 + k] : -1, k);
    end

    // Two persistent requesters must alternate
    keep_mask = 4'b0101;
    n0        = done_log.size();
    req_ready = 4'b0101;
    repeat (50) tick();
    chk("t3_count", (done_log.size() - n0) >= 6, 1'b1);
    for (int k = 0; k < 6; k++) begin
      chk("t3_alt", (done_log.size() > n0 + k) ? done_log[n0 + k] : -1, (k % 2) * 2);
    end
    keep_mask = '0;
    repeat (20) tick();

    // Operand change after grant must not reach L_shl
    rand_ops        = 1'b0;
    force_lat       = 4;
    req_a[63:32]    = 32'h0000_00F1;
    req_b[31:16]    = 16'd4;
    req_ready       = 4'b0010;
    for (int k = 0; k < 10 && !lif.L_shl_ready; k++) tick();
    chk("t4_issue", lif.L_shl_ready, 1'b1);
    req_a[63:32] = 32'hFFFF_FFFF;
    tick();
    chk("t4_hold", lif.L_shl_a, 32'h0000_00F1);
    repeat (6) tick();
    chk("t4_result", last_result, 32'h0000_0F10);

    // Reset while waiting on L_shl
    rand_ops  = 1'b1;
    force_lat = 0;
    mute      = 1'b1;
    req_ready = 4'b0010;
    repeat (4) tick();
    chk("t5_busy_before", busy, 1'b1);
    n0 = done_log.size();
    do_reset();
    chk("t5_no_done", done_log.size(), n0);
    mute      = 1'b0;
    req_ready = 4'b0111;
    repeat (30) tick();
    chk("t5_first", (done_log.size() > n0) ? done_log[n0] : -1, 0);

    // L_shl never answers
    mute      = 1'b1;
    n0        = done_log.size();
    req_ready = 4'b1000;
    repeat (TO + 8) tick();
`ifdef ARB_TIMEOUT_EN
    chk("t6_ops", done_log.size() - n0, 1);
    chk("t6_err", last_err, 1'b1);
    chk("t6_result", last_result, 32'h0);
`else
    chk("t6_busy", busy, 1'b1);
    chk("t6_nodone", done_log.size() - n0, 0);
`endif
    do_reset();
    mute      = 1'b0;
    req_ready = '0;

    // Random traffic, including requesters abandoning in-flight ops
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) == 0) req_ready = req_ready | 4'($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) req_ready = req_ready & ~grant;
      tick();
    end
    repeat (40) tick();
    chk("t7_drained", req_ready, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
